// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, fetch state encoding and widths shared by the MIPS front end.
package mips_pkg;
    localparam int INSTR_W = 32;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    typedef enum logic {S_FETCH, S_HOLD} fetch_state_t;
    function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] i);
        return i[31:26];
    endfunction
endpackage

// File: rtl/mips_next_pc.sv
// mips_next_pc: sequential / beq / j next-PC selection, jump taking priority over branch.
module mips_next_pc import mips_pkg::*; #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    output logic [ADDR_W-1:0]  npc
);
    logic [ADDR_W-1:0] pc4, br_off, j_target;
    logic unused_op;
    assign unused_op = ^instr[31:26];
    always_comb begin
        pc4      = pc + ADDR_W'(4);
        br_off   = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
        // masking instead of slicing keeps ADDR_W == 28 legal
        j_target = (pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({instr[25:0], 2'b00});
        npc      = jump ? j_target : (branch && zero) ? pc4 + br_off : pc4;
    end
endmodule

// File: rtl/mips_fetch.sv
// mips_fetch: PC register and variable-latency instruction fetch into a decode hold register.
// Define MIPS_FETCH_STATS_EN to add the fetch_count/stall_count outputs.
module mips_fetch import mips_pkg::*; #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valid,
    input  logic               id_ready,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump
`ifdef MIPS_FETCH_STATS_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
`endif
);
    fetch_state_t state, state_nxt;
    logic [ADDR_W-1:0] npc;
    logic fetched, xfer;

    assign fetched = state == S_FETCH && imem_valid;
    assign xfer    = state == S_HOLD && id_ready;

    always_ff @(posedge clk)
        state <= reset ? S_FETCH : state_nxt;

    always_comb
        state_nxt = fetched ? S_HOLD : xfer ? S_FETCH : state;

    always_comb begin
        imem_req  = state == S_FETCH && !reset;
        imem_addr = pc;
        opcode    = opcode_of(instr);
    end

    always_ff @(posedge clk)
        if (reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (fetched) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (xfer) begin
                pc          <= npc;
                instr_valid <= 1'b0;
            end
        end

    mips_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc(pc), .instr(instr), .branch(branch), .zero(zero), .jump(jump), .npc(npc)
    );

`ifdef MIPS_FETCH_STATS_EN
    always_ff @(posedge clk)
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            fetch_count <= fetch_count + 32'(xfer);
            stall_count <= stall_count + 32'((state == S_FETCH && !imem_valid) || (state == S_HOLD && !id_ready));
        end
`endif
endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: directed vectors with a scoreboard of expected held instructions.
module tb_mips_fetch;
    import mips_pkg::*;

    localparam logic [31:0] ADDI = 32'h2008_0005;
    localparam logic [31:0] JMP  = 32'h0800_0040;
    localparam logic [31:0] BEQ  = 32'h1000_FFFE;
    localparam logic [31:0] LW   = 32'h8C02_0000;

    typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;

    logic clk = 0, reset = 1;
    logic imem_req, imem_valid, instr_valid, id_ready, branch, zero, jump;
    logic [31:0] imem_addr, imem_rdata, instr, pc;
    logic [5:0] opcode;
    logic hi_req, hi_instr_valid, hi_id_ready;
    logic [31:0] hi_addr, hi_instr, hi_pc;
    logic [5:0] hi_opcode;
`ifdef MIPS_FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count, hi_fc, hi_sc;
`endif

    int vectors = 0, errors = 0;
    int lat = 0, waited = 0;
    bit manual = 0;
    logic [31:0] mem [logic [31:0]];
    exp_t sbq [$];

    always #5 clk = ~clk;

    mips_fetch dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instr(instr), .opcode(opcode),
        .pc(pc), .instr_valid(instr_valid), .id_ready(id_ready), .branch(branch),
        .zero(zero), .jump(jump)
`ifdef MIPS_FETCH_STATS_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    mips_fetch #(.RESET_PC(32'h4000_0010)) dut_hi (
        .clk(clk), .reset(reset), .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_rdata(JMP), .imem_valid(1'b1), .instr(hi_instr), .opcode(hi_opcode),
        .pc(hi_pc), .instr_valid(hi_instr_valid), .id_ready(hi_id_ready), .branch(1'b1),
        .zero(1'b1), .jump(1'b1)
`ifdef MIPS_FETCH_STATS_EN
        , .fetch_count(hi_fc), .stall_count(hi_sc)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ADDI;
    endfunction

    task automatic push(input logic [31:0] p, input logic [31:0] i);
        exp_t e;
        e.pc = p;
        e.instr = i;
        sbq.push_back(e);
    endtask

    task automatic wait_held();
        int n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("held timeout", instr_valid, 1);
    endtask

    task automatic xfer(input logic b, input logic z, input logic j, input logic [31:0] exp_npc);
        wait_held();
        branch = b; zero = z; jump = j; id_ready = 1;
        @(negedge clk);
        id_ready = 0; branch = 0; zero = 0; jump = 0;
        chk("next imem_addr", imem_addr, exp_npc);
        chk("req after xfer", imem_req, 1);
    endtask

    // memory model: answers a request after lat waiting cycles
    initial begin
        imem_valid = 0;
        imem_rdata = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!manual) begin
                if (imem_req && waited >= lat) begin
                    imem_valid = 1;
                    imem_rdata = mem_rd(imem_addr);
                    waited = 0;
                end else begin
                    imem_valid = 0;
                    waited = imem_req ? waited + 1 : 0;
                end
            end
        end
    end

    // monitor: each newly presented instruction is checked against the scoreboard
    initial begin
        logic prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (instr_valid && !prev) begin
                if (sbq.size() == 0) begin
                    chk("unexpected instr pc", pc, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("held pc", pc, e.pc);
                    chk("held instr", instr, e.instr);
                    chk("held opcode", opcode, e.instr[31:26]);
                end
            end
            prev = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit stable;
        mem[32'hC]   = JMP;
        mem[32'h100] = BEQ;
        mem[32'hFC]  = BEQ;
        mem[32'h104] = LW;
        id_ready = 1; hi_id_ready = 0; branch = 0; zero = 0; jump = 0;
        repeat (2) @(negedge clk);
        chk("reset req", imem_req, 0);
        chk("reset instr_valid", instr_valid, 0);
        chk("reset pc", pc, 0);
        chk("reset instr", instr, 0);
        chk("reset hi req", hi_req, 0);
        push(0, ADDI); push(4, ADDI); push(8, ADDI);
        reset = 0;
        #1;
        chk("first req", imem_req, 1);
        chk("first addr", imem_addr, 0);
        @(negedge clk);
        chk("zw valid c1", instr_valid, 1);
        chk("zw opcode", opcode, OP_ADDI);
        chk("hi pc", hi_pc, 32'h4000_0010);
        chk("hi opcode", hi_opcode, OP_J);
        hi_id_ready = 1;
        @(negedge clk);
        chk("zw valid c2", instr_valid, 0);
        chk("zw addr 4", imem_addr, 4);
        chk("jump priority addr", hi_addr, 32'h4000_0100);
        chk("jump priority req", hi_req, 1);
        hi_id_ready = 0;
        @(negedge clk);
        chk("zw valid c3", instr_valid, 1);
        @(negedge clk);
        chk("zw valid c4", instr_valid, 0);
        chk("zw addr 8", imem_addr, 8);
        id_ready = 0;
        repeat (5) begin
            @(negedge clk);
            chk("backpressure hold", {instr_valid, imem_req, pc, instr}, {1'b1, 1'b0, 32'h8, ADDI});
        end
        push(32'hC, JMP); push(32'h100, BEQ); push(32'hFC, BEQ); push(32'h100, BEQ); push(32'h104, LW);
        xfer(0, 0, 0, 32'hC);
        xfer(0, 0, 1, 32'h100);
        xfer(1, 1, 0, 32'hFC);
        xfer(1, 0, 0, 32'h100);
        lat = 3;
        xfer(1, 0, 0, 32'h104);
        id_ready = 1;
        n = 0;
        stable = 1;
        while (imem_req && n < 20) begin
            if (imem_addr !== 32'h104) stable = 0;
            n++;
            @(negedge clk);
        end
        id_ready = 0;
        chk("latency req cycles", n, 4);
        chk("latency addr stable", stable, 1);
        chk("latency instr_valid", instr_valid, 1);
        lat = 0;
        xfer(0, 0, 0, 32'h108);
        manual = 1;
        reset = 1;
        imem_valid = 1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mid reset req", imem_req, 0);
        chk("mid reset instr_valid", instr_valid, 0);
        chk("mid reset instr", instr, 0);
        push(0, ADDI);
        reset = 0;
        imem_valid = 0;
        manual = 0;
        #1;
        chk("post reset instr_valid", instr_valid, 0);
        chk("post reset addr", imem_addr, 0);
        wait_held();
`ifdef MIPS_FETCH_STATS_EN
        reset = 1;
        @(negedge clk);
        push(0, ADDI); push(4, ADDI); push(8, ADDI); push(32'hC, JMP);
        lat = 2;
        reset = 0;
        wait_held();
        @(negedge clk);
        lat = 0;
        xfer(0, 0, 0, 32'h4);
        xfer(0, 0, 0, 32'h8);
        xfer(0, 0, 0, 32'hC);
        chk("fetch_count", fetch_count, 3);
        chk("stall_count", stall_count, 3);
        wait_held();
`endif
        repeat (3) @(negedge clk);
        chk("scoreboard drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mips_fetch.md
Name: mips_fetch

Overview:
Instruction-fetch stage directly upstream of the decoder/control unit.
- Holds the PC and issues word reads to instruction memory with a req/valid handshake that tolerates variable latency.
- Presents the fetched instruction and its opcode field to decode and holds them until decode accepts.
- Computes the next PC from decode's branch/zero/jump resolution: sequential, beq target, or j target.

Parameters:
- ADDR_W, 32, PC and instruction-memory byte-address width. Must be at least 28.
- RESET_PC, 0, PC value loaded on reset. Must be word aligned (bits [1:0] = 0).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  read request to instruction memory
- imem_addr  output  ADDR_W  byte address of the word being read (equals pc)
- imem_rdata  input  32  read data; sampled only when imem_valid=1
- imem_valid  input  1  read data valid this cycle
- instr  output  32  held instruction word
- opcode  output  6  instr[31:26], fed to the control unit
- pc  output  ADDR_W  address of the held instruction
- instr_valid  output  1  instr/opcode/pc hold a valid instruction
- id_ready  input  1  decode consumes the instruction this cycle
- branch  input  1  control's branch output for the held instruction
- zero  input  1  ALU zero flag for the held instruction
- jump  input  1  control's jump output for the held instruction

Behaviour:
- Only clock: clk. Only reset: reset, synchronous and active-high.
- Reset values (all registered):
  - pc = RESET_PC; instr = 0; instr_valid = 0; state = S_FETCH.
  - imem_req = 0 during any cycle in which reset = 1.
- State S_FETCH:
  - imem_req = 1 and imem_addr = pc (combinational from state and pc).
  - On imem_valid = 1: instr <= imem_rdata, instr_valid <= 1, go to S_HOLD.
  - Otherwise stay in S_FETCH; no timeout.
- State S_HOLD:
  - imem_req = 0. instr, pc and opcode stay stable.
  - imem_valid in S_HOLD is ignored.
  - On id_ready = 1 (transfer): pc <= npc, instr_valid <= 0, go to S_FETCH.
  - While id_ready = 0: hold indefinitely.
  - branch, zero and jump are sampled only in the transfer cycle.
- Next-PC (npc):
  - pc4 = pc + 4.
  - jump = 1: npc = {pc4[ADDR_W-1:28], instr[25:0], 2'b00}.
  - else branch & zero: npc = pc4 + (sign-extended instr[15:0] << 2).
  - else: npc = pc4.
  - jump has priority when jump and branch are both 1.
  - All arithmetic is mod 2^ADDR_W. Wrap from max address to 0 is silent.
- Latency and throughput:
  - Zero-wait memory (valid in the request cycle) gives instr_valid in the next cycle.
  - Best-case throughput is one instruction per 2 cycles.
- Reset mid-operation:
  - Reset in S_FETCH or S_HOLD discards the held or pending instruction and restarts at RESET_PC.
  - imem_valid asserted while reset = 1 is ignored.
- id_ready while instr_valid = 0: ignored; no PC change.

Optional Feature:
- Macro: MIPS_FETCH_STATS_EN.
- Defined: adds two outputs, both 32-bit, cleared by reset, wrapping on overflow.
  - fetch_count: increments on each transfer.
  - stall_count: increments each cycle in S_FETCH with imem_valid = 0, plus each cycle in S_HOLD with id_ready = 0.
- Undefined: the ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Package mips_pkg:
  - Opcode constants: OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B.
  - Fetch state enum {S_FETCH, S_HOLD}.
  - INSTR_W = 32.
- Sub-module mips_next_pc: combinational; inputs pc, instr, branch, zero, jump; output npc. Shared with future pipelined datapath work.

Test Plan:
- Reset/zero-wait:
  - Stimulus: RESET_PC = 0x0, imem returns 0x20080005 (addi) with valid in the request cycle, id_ready = 1.
  - Expect: imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses every 2nd cycle; opcode = 0x08.
- Variable latency:
  - Stimulus: imem_valid delayed 3 cycles.
  - Expect: imem_req high for 4 cycles with imem_addr stable; instr_valid rises the cycle after valid.
- Taken beq:
  - Stimulus: pc = 0x100, instr = 0x1000FFFE, branch = 1, zero = 1.
  - Expect: next imem_addr = 0x0FC.
  - Same instruction with zero = 0: expect 0x104.
- Jump priority:
  - Stimulus: pc = 0x40000010, instr = 0x08000040, jump = 1, branch = 1, zero = 1.
  - Expect: next imem_addr = 0x40000100.
- Backpressure and reset:
  - Stimulus: hold id_ready = 0 for 5 cycles.
  - Expect: instr, pc, instr_valid stable, imem_req = 0.
  - Then assert reset in S_FETCH with imem_valid = 1 in the same cycle.
  - Expect: instr_valid = 0 and imem_addr = RESET_PC after reset deasserts.
- Stats (MIPS_FETCH_STATS_EN):
  - Stimulus: 3 transfers with 2 memory wait cycles and 1 backpressure cycle.
  - Expect: fetch_count = 3, stall_count = 3.
